// File: rtl/tt_bitlogic_pkg.sv
// ---------------------------------------------------------------------------
// tt_bitlogic_pkg
// Shared definitions for the bit-logic accumulator: operation encodings,
// control/flag bit positions on the bidirectional bus, the fixed output-enable
// pattern and the per-bit operation helper.
// Optional feature macro used by the top: BITLOGIC_PARITY_EN.
// ---------------------------------------------------------------------------
package tt_bitlogic_pkg;

   typedef enum logic [1:0] {
      OP_OR   = 2'b00,
      OP_AND  = 2'b01,
      OP_XOR  = 2'b10,
      OP_LOAD = 2'b11
   } op_e;

   // uio_in control bit positions
   localparam int CTL_OP_LSB  = 0;
   localparam int CTL_APPLY   = 2;
   localparam int CTL_UNDO    = 3;
   localparam int CTL_CLEAR   = 4;

   // uio_out flag bit positions
   localparam int FLAG_ZERO   = 5;
   localparam int FLAG_EMPTY  = 6;
   localparam int FLAG_PARITY = 7;

   localparam logic [7:0] UIO_OE_VAL = 8'b1110_0000;

   // Full-byte operation; callers keep only the low WIDTH bits.
   function automatic logic [7:0] bitop(input op_e op, input logic [7:0] a,
                                        input logic [7:0] d);
      logic [7:0] r;
      unique case (op)
         OP_OR:   r = a | d;
         OP_AND:  r = a & d;
         OP_XOR:  r = a ^ d;
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tt_bitlogic_hist.sv
// ---------------------------------------------------------------------------
// tt_bitlogic_hist
// Undo history: circular LIFO of DEPTH entries, WIDTH bits each. A push onto a
// full history silently overwrites the oldest entry and the count stays at
// DEPTH. Flush empties the history without touching the storage.
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   synchronous active-low reset (pointer and count only)
//   push_i   store din_i as the new top entry
//   pop_i    discard the top entry (ignored when empty)
//   flush_i  empty the history; dominates push/pop
//   din_i    value to push
//   dout_o   current top entry (valid when empty_o=0)
//   empty_o  history holds no entries
// ---------------------------------------------------------------------------
module tt_bitlogic_hist
   import tt_bitlogic_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    top_idx;
   logic [PW:0]      cnt_q, cnt_d;

   // DEPTH is a power of two, so the pointer wraps naturally; when full, the
   // write slot is exactly the oldest entry.
   assign top_idx = wr_ptr_q - PW'(1);
   assign dout_o  = mem_q[top_idx];
   assign empty_o = (cnt_q == '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         cnt_d = '0;
      end else if (push_i) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         if (cnt_q != FULL_CNT) cnt_d = cnt_q + 1'b1;
      end else if (pop_i && (cnt_q != '0)) begin
         wr_ptr_d = top_idx;
         cnt_d    = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/tt_um_bitlogic_acc.sv
// ---------------------------------------------------------------------------
// tt_um_bitlogic_acc
// Bit-logic accumulator with undo history. Rising edges on the apply, undo
// and clear strobes act on ACC; priority is clear > apply > undo.
// Optional feature: define BITLOGIC_PARITY_EN to drive uio_out[7] with the
// registered XOR-reduction of ACC (otherwise tied to 0).
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   ena      power-good (unused)
//   ui_in    operand D, low WIDTH bits used
//   uio_in   [1:0] op, [2] apply, [3] undo, [4] clear
//   uo_out   ACC, zero-extended to 8 bits
//   uio_out  [5] zero, [6] history empty, [7] parity, [4:0] zero
//   uio_oe   constant output-enable pattern
// ---------------------------------------------------------------------------
module tt_um_bitlogic_acc
   import tt_bitlogic_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] res, hist_top;
   logic [7:0]       res8;
   logic [2:0]       strb_now, strb_q, edge_w;
   logic             arm_q;
   logic             do_clr, do_app, do_pop, hist_empty;
   logic             zero_q, parity;
   logic             unused_ok;

   assign unused_ok = ^{ena, uio_in[7:5], ui_in, res8};

   // Strobe order in the vector: {clear, undo, apply}
   assign strb_now = {uio_in[CTL_CLEAR], uio_in[CTL_UNDO], uio_in[CTL_APPLY]};

   // arm_q masks the first cycle after reset so a strobe held high through
   // reset release is not mistaken for a fresh edge.
   assign edge_w = strb_now & ~strb_q & {3{arm_q}};
   assign do_clr = edge_w[2];
   assign do_app = edge_w[0] & ~do_clr;
   assign do_pop = edge_w[1] & ~do_clr & ~edge_w[0] & ~hist_empty;

   assign res8 = bitop(op_e'(uio_in[CTL_OP_LSB +: 2]), 8'(acc_q), ui_in);
   assign res  = res8[WIDTH-1:0];

   always_comb begin
      acc_d = acc_q;
      if (do_clr)      acc_d = '0;
      else if (do_app) acc_d = res;
      else if (do_pop) acc_d = hist_top;
   end

   tt_bitlogic_hist #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_hist (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (do_app),
      .pop_i   (do_pop),
      .flush_i (do_clr),
      .din_i   (acc_q),
      .dout_o  (hist_top),
      .empty_o (hist_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q  <= '0;
         strb_q <= '0;
         arm_q  <= 1'b0;
         zero_q <= 1'b1;
      end else begin
         acc_q  <= acc_d;
         strb_q <= strb_now;
         arm_q  <= 1'b1;
         zero_q <= (acc_d == '0);
      end
   end

`ifdef BITLOGIC_PARITY_EN
   logic par_q;
   always_ff @(posedge clk) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= ^acc_d;
   end
   assign parity = par_q;
`else
   assign parity = 1'b0;
`endif

   always_comb begin
      uio_out              = '0;
      uio_out[FLAG_ZERO]   = zero_q;
      uio_out[FLAG_EMPTY]  = hist_empty;
      uio_out[FLAG_PARITY] = parity;
   end

   assign uo_out = 8'(acc_q);
   assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_bitlogic_acc.sv
module tb_tt_um_bitlogic_acc;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = '0;
   logic [7:0] uio_in = '0;
   logic [7:0] uo_out, uio_out, uio_oe;
   logic [7:0] uo4, uio4, oe4;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: accumulator values and undo stacks as queues
   logic [7:0] acc8, acc4;
   logic [7:0] h8[$];
   logic [7:0] h4[$];
   logic [2:0] prev;   // previous {clear, undo, apply} levels

   always #5 clk = ~clk;

   tt_um_bitlogic_acc #(.WIDTH(8), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe));

   tt_um_bitlogic_acc #(.WIDTH(4), .DEPTH(DEPTH)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo4), .uio_out(uio4), .uio_oe(oe4));

   function automatic logic [7:0] op_ref(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] d, input logic [7:0] mask);
      logic [7:0] r;
      case (op)
         2'd0: r = a | d;
         2'd1: r = a & d;
         2'd2: r = a ^ d;
         default: r = d;
      endcase
      return r & mask;
   endfunction

   function automatic logic [7:0] flags_ref(input logic [7:0] acc, input int hsize);
      logic [7:0] f;
      f = 8'h00;
      f[5] = (acc == 8'h00);
      f[6] = (hsize == 0);
`ifdef BITLOGIC_PARITY_EN
      f[7] = ^acc;
`else
      f[7] = 1'b0;
`endif
      return f;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   // Apply the behavioural rules for one clock edge.
   task automatic model(input logic [7:0] ui, input logic [7:0] uio);
      logic ap, un, cl;
      if (!rst_n) begin
         acc8 = 8'h00; acc4 = 8'h00;
         h8.delete(); h4.delete();
         prev = uio[4:2];
         return;
      end
      ap = uio[2] & ~prev[0];
      un = uio[3] & ~prev[1];
      cl = uio[4] & ~prev[2];
      prev = uio[4:2];
      if (cl) begin
         acc8 = 8'h00; acc4 = 8'h00;
         h8.delete(); h4.delete();
      end else if (ap) begin
         h8.push_back(acc8);
         h4.push_back(acc4);
         if (h8.size() > DEPTH) void'(h8.pop_front());
         if (h4.size() > DEPTH) void'(h4.pop_front());
         acc8 = op_ref(uio[1:0], acc8, ui, 8'hFF);
         acc4 = op_ref(uio[1:0], acc4, ui, 8'h0F);
      end else if (un) begin
         if (h8.size() > 0) acc8 = h8.pop_back();
         if (h4.size() > 0) acc4 = h4.pop_back();
      end
   endtask

   task automatic check_all();
      chk("uo_out", uo_out, acc8);
      chk("uio_out", uio_out, flags_ref(acc8, h8.size()));
      chk("uio_oe", uio_oe, 8'hE0);
      chk("uo_out_w4", uo4, acc4);
      chk("uio_out_w4", uio4, flags_ref(acc4, h4.size()));
   endtask

   task automatic step(input logic [7:0] ui, input logic [7:0] uio);
      @(negedge clk);
      ui_in  = ui;
      uio_in = uio;
      model(ui, uio);
      @(posedge clk);
      #1;
      check_all();
   endtask

   // Raise a strobe for one cycle, then drop it with op/data unchanged.
   task automatic pulse(input logic [1:0] op, input logic [7:0] strb, input logic [7:0] d);
      step(d, {6'b0, op} | strb);
      step(d, {6'b0, op});
   endtask

   localparam logic [7:0] S_APP = 8'h04, S_UND = 8'h08, S_CLR = 8'h10;

   initial begin
      // Reset, with apply strobe raised during reset and held past release
      rst_n = 1'b0;
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);
      chk("reset_uio_out", uio_out, 8'h60);
      step(8'h55, S_APP | 8'h03);
      rst_n = 1'b1;
      step(8'h55, S_APP | 8'h03);
      chk("held_through_reset", uo_out, 8'h00);
      step(8'h55, 8'h03);

      // LOAD / OR / AND / XOR chain
      pulse(2'd3, S_APP, 8'h3C);
      chk("load_3c", uo_out, 8'h3C);
      pulse(2'd0, S_APP, 8'h81);
      chk("or_81", uo_out, 8'hBD);
      pulse(2'd1, S_APP, 8'h0F);
      chk("and_0f", uo_out, 8'h0D);
      pulse(2'd2, S_APP, 8'h0D);
      chk("xor_zero_flag", uio_out[5], 1'b1);

      // History depth: five loads, five undos
      pulse(2'd3, S_CLR, 8'h00);
      for (int i = 1; i <= 5; i++) pulse(2'd3, S_APP, 8'(i));
      for (int i = 0; i < 5; i++) pulse(2'd3, S_UND, 8'h00);
      chk("undo_floor", uo_out, 8'h01);
      chk("undo_empty", uio_out[6], 1'b1);

      // Simultaneous edges
      pulse(2'd3, S_APP | S_UND, 8'hA5);
      chk("apply_beats_undo", uo_out, 8'hA5);
      pulse(2'd3, S_APP | S_CLR, 8'h5A);
      chk("clear_beats_apply", uio_out, 8'h60);

      // Level-held apply: one update only
      pulse(2'd3, S_APP, 8'h11);
      for (int i = 0; i < 10; i++) step(8'(i + 8'h20), S_APP | 8'h00);
      chk("held_apply_once", uo_out, 8'h31);
      step(8'h00, 8'h00);

      // Width masking on the 4-bit instance
      pulse(2'd3, S_APP, 8'hFF);
      chk("w4_mask", uo4, 8'h0F);

      // Parity on a known value
      pulse(2'd3, S_APP, 8'h07);
`ifdef BITLOGIC_PARITY_EN
      chk("parity_07", uio_out[7], 1'b1);
`else
      chk("parity_off", uio_out[7], 1'b0);
`endif

      // Randomized operation mix
      for (int i = 0; i < 400; i++) begin
         step(8'($urandom), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tt_um_bitlogic_acc.md
TT_UM_BITLOGIC_ACC -- requirements
Module: tt_um_bitlogic_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, accumulator/operand width, legal 1..8.
REQ-002 SHALL have parameter DEPTH, default 4, undo-history entries, power of two, legal 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port ena  input  1  power-good, ignored.
REQ-006 SHALL have port ui_in  input  8  operand D; bits [WIDTH-1:0] used.
REQ-007 SHALL have port uio_in  input  8  control: [1:0] op, [2] apply strobe, [3] undo strobe, [4] clear; [7:5] ignored.
REQ-008 SHALL have port uo_out  output  8  accumulator ACC, zero-extended above WIDTH.
REQ-009 SHALL have port uio_out  output  8  [5] zero flag, [6] history-empty, [7] parity; [4:0] constant 0.
REQ-010 SHALL have port uio_oe  output  8  constant 8'b1110_0000.

Function
REQ-011 SHALL decode op: 00 OR, 01 AND, 10 XOR, 11 LOAD; result R = op(ACC, D[WIDTH-1:0]) per bit.
REQ-012 SHALL detect rising edges on uio_in[2], [3], [4] by comparing the current sample with a one-cycle registered copy.
REQ-013 SHALL, on an apply edge in cycle N, push the old ACC to history and set ACC=R; new ACC visible on uo_out in cycle N+1.
REQ-014 SHALL, on an undo edge with history non-empty, pop the top entry into ACC in cycle N+1.
REQ-015 SHALL treat undo with history empty as a no-op; ACC unchanged.
REQ-016 SHALL, when history holds DEPTH entries and an apply occurs, overwrite the oldest entry; count stays DEPTH.
REQ-017 SHALL, on a clear edge, set ACC=0 and empty history in cycle N+1.
REQ-018 SHALL prioritise simultaneous edges: clear > apply > undo; lower-priority edges in that cycle are discarded.
REQ-019 SHALL hold ACC and history when no edge occurs; level-high strobes never repeat an action.
REQ-020 SHALL drive uio_out[5]=1 iff ACC==0, uio_out[6]=1 iff history count==0, both registered with ACC.
REQ-021 SHALL ignore ui_in/uio_in bits above WIDTH or outside REQ-007.

Reset
REQ-022 SHALL, while rst_n=0 at a rising clk edge, set ACC=0, history count=0, edge registers=0.
REQ-023 SHALL give post-reset outputs uo_out=0, uio_out=8'b0110_0000 (zero=1, empty=1, parity=0).
REQ-024 SHALL let reset override any edge in the same cycle; a strobe held high through reset release produces no action.

Configuration
REQ-025 SHALL use macro BITLOGIC_PARITY_EN.
REQ-026 SHALL, with BITLOGIC_PARITY_EN defined, drive uio_out[7] = XOR-reduction of ACC, registered with ACC.
REQ-027 SHALL, without BITLOGIC_PARITY_EN, tie uio_out[7]=0 and synthesise no parity logic.

Structure
REQ-028 SHALL place op encodings, uio_in control-bit indices, uio_out flag indices and UIO_OE value in package tt_bitlogic_pkg.
REQ-029 SHALL implement history as sub-module tt_bitlogic_hist: circular LIFO, WIDTH x DEPTH, push/pop/flush, empty flag, overwrite-oldest on full push.

Verification
REQ-030 SHALL cover: reset, op=11 D=0x3C apply -> uo_out=0x3C next cycle, uio_out[6]=0.
REQ-031 SHALL cover: ACC=0x3C, op=00 D=0x81 apply -> 0xBD; op=01 D=0x0F apply -> 0x0D; op=10 D=0x0D apply -> 0x00, zero flag=1.
REQ-032 SHALL cover: DEPTH=4, five LOAD applies 1,2,3,4,5 then five undos -> 4,3,2,1 then 1 held, empty flag=1 after fourth undo.
REQ-033 SHALL cover: apply and undo edges same cycle -> apply only; clear+apply same cycle -> ACC=0, empty=1.
REQ-034 SHALL cover: apply strobe held high 10 cycles -> exactly one update; WIDTH=4, LOAD D=0xFF -> uo_out=0x0F.
REQ-035 SHALL cover: PARITY_EN defined, ACC=0x07 -> uio_out[7]=1; undefined -> uio_out[7]=0 always.
